// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 90,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              o_fifo_full,
  output logic              o_fifo_empty,
  output logic              o_fifo_almost_full,
  output logic              o_fifo_almost_empty,
  output logic [CNT_W-1:0]  o_fifo_count,
  output logic              o_overflow,
  output logic              o_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    LAST   = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              wr_acc, rd_acc;

  // Acceptance uses the registered flags, so a same-cycle opposite op never unblocks.
  assign wr_acc = wr_en && !o_fifo_full;
  assign rd_acc = rd_en && !o_fifo_empty;

  always_comb begin
    cnt_nxt = o_fifo_count;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = o_fifo_count + 1'b1;
      2'b01:   cnt_nxt = o_fifo_count - 1'b1;
      default: cnt_nxt = o_fifo_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr             <= '0;
      rd_addr             <= '0;
      o_fifo_count        <= '0;
      o_fifo_full         <= 1'b0;
      o_fifo_empty        <= 1'b1;
      o_fifo_almost_full  <= 1'b0;
      o_fifo_almost_empty <= 1'b1;
      o_overflow          <= 1'b0;
      o_underflow         <= 1'b0;
    end else begin
      if (wr_acc) wr_addr <= (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
      if (rd_acc) rd_addr <= (rd_addr == LAST) ? '0 : rd_addr + 1'b1;
      o_fifo_count        <= cnt_nxt;
      o_fifo_full         <= (cnt_nxt == FULL_C);
      o_fifo_empty        <= (cnt_nxt == '0);
      o_fifo_almost_full  <= (cnt_nxt >= AF_C);
      o_fifo_almost_empty <= (cnt_nxt <= AE_C);
      if (wr_en && o_fifo_full)  o_overflow  <= 1'b1;
      if (rd_en && o_fifo_empty) o_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_addr] <= wr_data;
  end

`ifdef FIFO_FWFT_EN
  assign rd_data = o_fifo_empty ? '0 : mem[rd_addr];
`else
  always_ff @(posedge clk) begin
    if (rst)         rd_data <= '0;
    else if (rd_acc) rd_data <= mem[rd_addr];
  end
`endif

endmodule
